mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage consumer of the EX/MEM pipeline register. Takes the registered
//  memory request (address, store data, size, read/write) and runs one data-bus
//  transaction with a valid/ready request and an rvalid response. Holds stall_o
//  until the access completes, then presents the sign/zero-extended load data
//  for writeback. It issues one access per instruction and allows at most one
//  outstanding transaction.
// PARAMETERS
//  TIMEOUT   64  Max cycles spent in REQ+WAIT before abort; must be >= 2.
//  CNT_W     7   Timeout counter width; must satisfy 2^CNT_W > TIMEOUT.
// PORTS
//  clk_i          in   1   clock, all state changes on rising edge
//  rst_n_i        in   1   asynchronous reset, active low
//  MemEn_i        in   1   instruction in EX/MEM is a load or store
//  MemRW_i        in   1   1 = store, 0 = load
//  funct3_i       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
//  alu_i          in   32  effective byte address
//  RegDataB_i     in   32  store data, right-aligned
//  stall_o        out  1   freezes PC/IF/ID/EX and the EX/MEM register
//  bus_valid_o    out  1   request valid
//  bus_ready_i    in   1   bus accepts the request this cycle
//  bus_addr_o     out  32  word-aligned address ({alu[31:2],2'b00})
//  bus_we_o       out  1   write enable
//  bus_wstrb_o    out  4   byte strobes (0000 on loads)
//  bus_wdata_o    out  32  store data shifted into its byte lanes
//  bus_rvalid_i   in   1   response valid, for loads and stores
//  bus_rdata_i    in   32  read word
//  load_data_o    out  32  extended load result, valid while done_o
//  done_o         out  1   access finished; 1-cycle pulse
//  err_o          out  1   access failed; qualified by done_o
//  err_code_o     out  2   01 misaligned/illegal funct3, 10 timeout, 00 ok
// BEHAVIOUR
//  Reset (async): state=IDLE. All registered outputs are 0: bus_valid_o,
//   bus_we_o, bus_wstrb_o, bus_addr_o, bus_wdata_o, load_data_o, done_o, err_o,
//   err_code_o. Timeout counter=0. bus_valid_o drops immediately, even mid-access.
//  Misaligned: H/HU with alu[0]=1; W with alu[1:0]!=0; or illegal funct3.
//  stall_o (combinational) = (IDLE & MemEn_i) | REQ | WAIT. It is 0 in DONE.
//  FSM:
//   IDLE: if !MemEn_i, stay. If misaligned: next DONE, err_code=01, no bus
//    activity. Else latch addr, we, wstrb, wdata and byte offset; next REQ.
//    wstrb: B=0001<<a[1:0]; H=0011<<a[1:0]; W=1111.
//    wdata=RegDataB_i<<(8*a[1:0]).
//   REQ: bus_valid_o=1; address/data held stable. On bus_ready_i go to WAIT and
//    clear bus_valid_o. If bus_rvalid_i is also high that cycle, go to DONE.
//   WAIT: on bus_rvalid_i go to DONE. For loads, capture bus_rdata_i>>(8*off)
//    and extend it: B/H sign-extend bit 7/15; BU/HU zero-extend; W as-is.
//   REQ/WAIT timeout: the counter increments each cycle spent in REQ or WAIT.
//    At TIMEOUT, go to DONE with err=1, code=10, load_data=0, and drop valid.
//   DONE: done_o=1 for one cycle; the pipeline advances at this edge. Next
//    state is IDLE unconditionally, and MemEn_i is ignored in DONE because the
//    inputs still hold the completed instruction. Counter clears.
//  Latency, 0-wait bus (ready in the REQ cycle, rvalid one cycle later): IDLE,
//   REQ, WAIT, DONE, i.e. stall for 3 cycles and done in the 4th.
//  A stray bus_rvalid_i in IDLE or DONE is ignored. Stores produce
//   load_data_o=0.
//  Inputs are sampled only in IDLE; later changes do not affect the access.
// TESTING
//  LB alu=0x1003, rdata=0x80FF_1234 -> wstrb 0000; load_data=0xFFFF_FF80;
//   done_o after 3 stall cycles.
//  SH alu=0x2002, RegDataB=0x0000_ABCD -> wdata=0xABCD_0000, wstrb=1100,
//   addr=0x2000, we=1.
//  LW alu=0x3001 -> no bus_valid_o; stall_o 1 cycle; done_o with err_code=01.
//  LHU alu=0x4002, ready delayed 5 cycles, rdata=0xF00D_0000 ->
//   load_data=0x0000_F00D; bus_valid_o held stable throughout.
//  Bus never asserts ready, TIMEOUT=64 -> done_o after 64 REQ cycles;
//   err_code=10; bus_valid_o low.
//  rst_n_i pulsed low in WAIT -> all outputs 0 immediately; stall_o=0 unless
//   MemEn_i; the late rvalid is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_unit
//  Brief   : Memory-stage bus master. Runs one valid/ready + rvalid data access
//            per instruction and stalls the pipeline until the access ends.
//  Rev     : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        MemEn_i,
  input  logic        MemRW_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] RegDataB_i,
  output logic        stall_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CODE_OK   = 2'b00;
  localparam logic [1:0] CODE_MIS  = 2'b01;
  localparam logic [1:0] CODE_TOUT = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic             valid_q, valid_d;
  logic [31:0]      ld_q, ld_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        mis_w;
  logic        legal_w;
  logic [3:0]  strb_w;
  logic [31:0] shdata_w;
  logic [31:0] rshift_w;
  logic [31:0] ldext_w;
  logic        rsp_w;
  logic        tout_w;

  // Request decode on the live EX/MEM inputs, only consumed in IDLE
  always_comb begin
    legal_w = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
              (funct3_i == 3'b100) || (funct3_i == 3'b101);
    mis_w   = !legal_w ||
              ((funct3_i[1:0] == 2'b01) && alu_i[0]) ||
              ((funct3_i[1:0] == 2'b10) && (alu_i[1:0] != 2'b00));
    case (funct3_i[1:0])
      2'b00:   strb_w = 4'b0001 << alu_i[1:0];
      2'b01:   strb_w = 4'b0011 << alu_i[1:0];
      default: strb_w = 4'b1111;
    endcase
    shdata_w = RegDataB_i << {alu_i[1:0], 3'b000};
  end

  always_comb begin
    rshift_w = bus_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ldext_w = {{24{rshift_w[7]}}, rshift_w[7:0]};
      3'b001:  ldext_w = {{16{rshift_w[15]}}, rshift_w[15:0]};
      3'b100:  ldext_w = {24'd0, rshift_w[7:0]};
      3'b101:  ldext_w = {16'd0, rshift_w[15:0]};
      default: ldext_w = rshift_w;
    endcase
  end

  // A response wins over a timeout landing in the same cycle
  assign rsp_w  = ((state_q == S_REQ) && bus_ready_i && bus_rvalid_i) ||
                  ((state_q == S_WAIT) && bus_rvalid_i);
  assign tout_w = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                  (cnt_q >= TO_LAST) && !rsp_w;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (MemEn_i) begin
          state_d = mis_w ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (rsp_w || tout_w) begin
          state_d = S_DONE;
        end else if (bus_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_w || tout_w) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o = ((state_q == S_IDLE) && MemEn_i) || (state_q == S_REQ) || (state_q == S_WAIT);

    addr_d  = addr_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    valid_d = valid_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (MemEn_i && mis_w) begin
          done_d = 1'b1;
          err_d  = 1'b1;
          code_d = CODE_MIS;
          ld_d   = 32'd0;
        end else if (MemEn_i) begin
          addr_d  = {alu_i[31:2], 2'b00};
          we_d    = MemRW_i;
          wstrb_d = MemRW_i ? strb_w : 4'b0000;
          wdata_d = shdata_w;
          off_d   = alu_i[1:0];
          f3_d    = funct3_i;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_ready_i) begin
          valid_d = 1'b0;
        end
        if (rsp_w) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b0;
          code_d  = CODE_OK;
          ld_d    = we_q ? 32'd0 : ldext_w;
        end else if (tout_w) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          code_d  = CODE_TOUT;
          ld_d    = 32'd0;
        end
      end
      default: begin
        err_d  = 1'b0;
        code_d = CODE_OK;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'd0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      valid_q <= 1'b0;
      ld_q    <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= CODE_OK;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      valid_q <= valid_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_valid_o = valid_q;
  assign bus_addr_o  = addr_q;
  assign bus_we_o    = we_q;
  assign bus_wstrb_o = wstrb_q;
  assign bus_wdata_o = wdata_q;
  assign load_data_o = ld_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_access_unit
//  Brief   : Vector table plus hand sequences for mem_access_unit, with a
//            completion scoreboard.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        MemEn_i, MemRW_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_i, RegDataB_i;
  logic        stall_o, bus_valid_o, bus_ready_i, bus_we_o, bus_rvalid_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i, load_data_o;
  logic [3:0]  bus_wstrb_o;
  logic        done_o, err_o;
  logic [1:0]  err_code_o;

  mem_access_unit #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .MemEn_i(MemEn_i), .MemRW_i(MemRW_i),
    .funct3_i(funct3_i), .alu_i(alu_i), .RegDataB_i(RegDataB_i),
    .stall_o(stall_o), .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .load_data_o(load_data_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] regb;
    logic [31:0] rdata;
    int          dly;
    bit          both;
    bit          bus;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic        err;
    logic [1:0]  code;
    int          stalls;
  } vec_t;

  typedef struct {
    logic [31:0] ld;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic rw, input logic [2:0] f3, input logic [31:0] alu,
                              input logic [31:0] regb, input logic [31:0] rdata, input int dly,
                              input bit both, input bit bus, input logic [31:0] addr,
                              input logic [3:0] wstrb, input logic [31:0] wdata,
                              input logic [31:0] ld, input logic err, input logic [1:0] code,
                              input int stalls);
    vec_t v;
    v.rw = rw; v.f3 = f3; v.alu = alu; v.regb = regb; v.rdata = rdata; v.dly = dly;
    v.both = both; v.bus = bus; v.addr = addr; v.wstrb = wstrb; v.wdata = wdata;
    v.ld = ld; v.err = err; v.code = code; v.stalls = stalls;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc = 0;
    int   vcnt = 0;
    int   stalls = 0;
    bit   seen = 0;
    bit   acc = 0;
    bit   fin = 0;
    exp_t e;
    @(negedge clk_i);
    MemEn_i = 1'b1; MemRW_i = v.rw; funct3_i = v.f3; alu_i = v.alu; RegDataB_i = v.regb;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = v.rdata;
    sb_q.push_back('{ld: v.ld, err: v.err, code: v.code});
    while (!fin) begin
      #1;
      if (done_o) begin
        if (sb_q.size() == 0) begin
          check($sformatf("v%0d sb_empty", idx), 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("v%0d load_data", idx), load_data_o, e.ld);
          check($sformatf("v%0d err", idx), {31'd0, err_o}, {31'd0, e.err});
          check($sformatf("v%0d err_code", idx), {30'd0, err_code_o}, {30'd0, e.code});
        end
        check($sformatf("v%0d stall_cycles", idx), stalls, v.stalls);
        check($sformatf("v%0d stall_in_done", idx), {31'd0, stall_o}, 32'd0);
        check($sformatf("v%0d valid_in_done", idx), {31'd0, bus_valid_o}, 32'd0);
        fin = 1;
        MemEn_i = 1'b0; bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
      end else if (cyc >= 200) begin
        check($sformatf("v%0d done_timeout", idx), 32'd0, 32'd1);
        fin = 1;
        MemEn_i = 1'b0; bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
      end else begin
        if (stall_o) stalls++;
        if (bus_valid_o) begin
          if (!v.bus) check($sformatf("v%0d unexpected_valid", idx), 32'd1, 32'd0);
          else if (!seen) begin
            check($sformatf("v%0d addr", idx), bus_addr_o, v.addr);
            check($sformatf("v%0d we", idx), {31'd0, bus_we_o}, {31'd0, v.rw});
            check($sformatf("v%0d wstrb", idx), {28'd0, bus_wstrb_o}, {28'd0, v.wstrb});
            check($sformatf("v%0d wdata", idx), bus_wdata_o, v.wdata);
          end else if (bus_addr_o !== v.addr || bus_wdata_o !== v.wdata) begin
            check($sformatf("v%0d req_stable", idx), bus_addr_o ^ bus_wdata_o, v.addr ^ v.wdata);
          end
          seen = 1;
        end
        if (cyc >= 1) begin
          alu_i = $urandom; RegDataB_i = $urandom;
        end
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
        if (acc) bus_rvalid_i = 1'b1;
        else if (bus_valid_o) begin
          if (vcnt >= v.dly) begin
            bus_ready_i = 1'b1; bus_rvalid_i = v.both; acc = 1;
          end
          vcnt++;
        end
        cyc++;
        @(negedge clk_i);
      end
    end
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = mk(0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 1, 32'h1000, 4'b0000, 32'h0, 32'hFFFF_FF80, 0, 2'b00, 3);
    tbl[1]  = mk(1, 3'b001, 32'h2002, 32'h0000_ABCD, 32'hDEAD_BEEF, 0, 0, 1, 32'h2000, 4'b1100, 32'hABCD_0000, 32'h0, 0, 2'b00, 3);
    tbl[2]  = mk(0, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 2'b01, 1);
    tbl[3]  = mk(0, 3'b101, 32'h4002, 32'h0, 32'hF00D_0000, 5, 0, 1, 32'h4000, 4'b0000, 32'h0, 32'h0000_F00D, 0, 2'b00, 8);
    tbl[4]  = mk(0, 3'b010, 32'h5000, 32'h0, 32'h1111_1111, 1000, 0, 1, 32'h5000, 4'b0000, 32'h0, 32'h0, 1, 2'b10, 65);
    tbl[5]  = mk(0, 3'b001, 32'h6002, 32'h0, 32'h8001_0000, 0, 0, 1, 32'h6000, 4'b0000, 32'h0, 32'hFFFF_8001, 0, 2'b00, 3);
    tbl[6]  = mk(0, 3'b100, 32'h7001, 32'h0, 32'h0000_AB00, 0, 0, 1, 32'h7000, 4'b0000, 32'h0, 32'h0000_00AB, 0, 2'b00, 3);
    tbl[7]  = mk(1, 3'b000, 32'h8001, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 1, 32'h8000, 4'b0010, 32'h3456_7800, 32'h0, 0, 2'b00, 3);
    tbl[8]  = mk(1, 3'b010, 32'h9000, 32'hCAFE_F00D, 32'h0, 1, 0, 1, 32'h9000, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 2'b00, 4);
    tbl[9]  = mk(0, 3'b011, 32'hA000, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 2'b01, 1);
    tbl[10] = mk(0, 3'b001, 32'hB001, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 2'b01, 1);
    tbl[11] = mk(0, 3'b010, 32'hC000, 32'h0, 32'h1234_5678, 2, 0, 1, 32'hC000, 4'b0000, 32'h0, 32'h1234_5678, 0, 2'b00, 5);
    tbl[12] = mk(0, 3'b000, 32'hD001, 32'h0, 32'h0000_7F00, 0, 1, 1, 32'hD000, 4'b0000, 32'h0, 32'h0000_007F, 0, 2'b00, 2);

    rst_n_i = 1'b0; MemEn_i = 1'b0; MemRW_i = 1'b0; funct3_i = 3'b000;
    alu_i = 32'h0; RegDataB_i = 32'h0; bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
    bus_rdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst valid", {31'd0, bus_valid_o}, 32'd0);
    check("rst outs", bus_addr_o | bus_wdata_o | load_data_o |
          {27'd0, bus_we_o, bus_wstrb_o} | {29'd0, done_o, err_code_o} | {31'd0, err_o}, 32'd0);
    check("rst stall", {31'd0, stall_o}, 32'd0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    check("idle no_memen stall", {31'd0, stall_o}, 32'd0);
    check("idle no_memen done", {31'd0, done_o}, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

    // Reset pulsed while an access sits in WAIT
    @(negedge clk_i);
    MemEn_i = 1'b1; MemRW_i = 1'b0; funct3_i = 3'b010; alu_i = 32'hF000;
    @(negedge clk_i); #1;
    check("rstwait req_valid", {31'd0, bus_valid_o}, 32'd1);
    bus_ready_i = 1'b1;
    @(negedge clk_i); #1;
    bus_ready_i = 1'b0;
    check("rstwait in_wait stall", {31'd0, stall_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    check("rstwait outs", bus_addr_o | bus_wdata_o | load_data_o |
          {27'd0, bus_we_o, bus_wstrb_o} | {29'd0, done_o, err_code_o} |
          {30'd0, err_o, bus_valid_o}, 32'd0);
    check("rstwait stall memen", {31'd0, stall_o}, 32'd1);
    MemEn_i = 1'b0;
    #1;
    check("rstwait stall idle", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("rstwait late_rvalid done c%0d", k), {31'd0, done_o}, 32'd0);
      check($sformatf("rstwait late_rvalid valid c%0d", k), {31'd0, bus_valid_o}, 32'd0);
      @(negedge clk_i);
    end
    check("sb drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
